flick_conditioner: RTL and testbench

//  Upstream input stage for the bound flasher: turns the raw, asynchronous, bouncy

---
 rtl/flick_conditioner.sv | 128 ++++++++++++
 tb/tb_flick_conditioner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flick_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : flick_conditioner
// Function : Synchronises and debounces the raw flick push-button into a clean
//            level with press/release strobes and a saturating bounce counter.
// Revision : 1.0
// ============================================================================
module flick_conditioner #(
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       flick,
    output logic       flick_pulse,
    output logic       release_pulse,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_btn_n;
    logic             r_s1_q;
    logic             r_s2_q;
    state_t           r_state_q;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_flick_q;
    logic             w_flick_d;
    logic             r_flick_pulse_q;
    logic             w_flick_pulse_d;
    logic             r_release_pulse_q;
    logic             w_release_pulse_d;
    logic [7:0]       r_glitch_q;
    logic [7:0]       w_glitch_d;
    logic [7:0]       w_glitch_inc;

    assign w_btn_n      = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;
    assign w_glitch_inc = (r_glitch_q == 8'hFF) ? r_glitch_q : r_glitch_q + 8'd1;

    always_comb begin
        w_state_d         = r_state_q;
        w_cnt_d           = r_cnt_q;
        w_flick_d         = r_flick_q;
        w_flick_pulse_d   = 1'b0;
        w_release_pulse_d = 1'b0;
        w_glitch_d        = r_glitch_q;
        case (r_state_q)
            S_RELEASED: begin
                if (r_s2_q) begin
                    w_state_d = S_PRESS_WAIT;
                    w_cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!r_s2_q) begin
                    w_state_d  = S_RELEASED;
                    w_glitch_d = w_glitch_inc;
                end else if (r_cnt_q == c_CNT_LAST) begin
                    w_state_d       = S_PRESSED;
                    w_flick_d       = 1'b1;
                    w_flick_pulse_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!r_s2_q) begin
                    w_state_d = S_RELEASE_WAIT;
                    w_cnt_d   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                // A bounce back to pressed keeps flick high and emits no new strobe.
                if (r_s2_q) begin
                    w_state_d  = S_PRESSED;
                    w_glitch_d = w_glitch_inc;
                end else if (r_cnt_q == c_CNT_LAST) begin
                    w_state_d         = S_RELEASED;
                    w_flick_d         = 1'b0;
                    w_release_pulse_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            default: w_state_d = S_RELEASED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_q            <= 1'b0;
            r_s2_q            <= 1'b0;
            r_state_q         <= S_RELEASED;
            r_cnt_q           <= '0;
            r_flick_q         <= 1'b0;
            r_flick_pulse_q   <= 1'b0;
            r_release_pulse_q <= 1'b0;
            r_glitch_q        <= 8'h00;
        end else begin
            r_s1_q            <= w_btn_n;
            r_s2_q            <= r_s1_q;
            r_state_q         <= w_state_d;
            r_cnt_q           <= w_cnt_d;
            r_flick_q         <= w_flick_d;
            r_flick_pulse_q   <= w_flick_pulse_d;
            r_release_pulse_q <= w_release_pulse_d;
            r_glitch_q        <= w_glitch_d;
        end
    end

    assign flick         = r_flick_q;
    assign flick_pulse   = r_flick_pulse_q;
    assign release_pulse = r_release_pulse_q;
    assign glitch_cnt    = r_glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_flick_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_flick_conditioner
// Function : Self-checking bench for flick_conditioner against a run-length
//            debounce model.
// Revision : 1.0
// ============================================================================
module tb_flick_conditioner;

    localparam int c_D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic       btn_raw_ah;
    logic       flick, flick_pulse, release_pulse;
    logic [7:0] glitch_cnt;
    logic       flick_ah, flick_pulse_ah, release_pulse_ah;
    logic [7:0] glitch_cnt_ah;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: 2-deep sync pipe, debounced level, length of current disagreeing run.
    logic m_p0 = 1'b0, m_p1 = 1'b0;
    logic m_level = 1'b0, m_fp = 1'b0, m_rp = 1'b0;
    int   m_run = 0, m_glitch = 0;

    always #5 clk = ~clk;

    flick_conditioner #(.BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(c_D), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .flick(flick),
        .flick_pulse(flick_pulse), .release_pulse(release_pulse), .glitch_cnt(glitch_cnt)
    );

    flick_conditioner #(.BTN_ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(c_D), .CNT_W(16)) u_dut_ah (
        .clk(clk), .reset(reset), .btn_raw(btn_raw_ah), .flick(flick_ah),
        .flick_pulse(flick_pulse_ah), .release_pulse(release_pulse_ah), .glitch_cnt(glitch_cnt_ah)
    );

    task automatic tick();
        logic pressed;
        logic s2_now;
        @(posedge clk);
        pressed = (btn_raw == 1'b0);
        if (reset) begin
            m_p0 = 1'b0; m_p1 = 1'b0; m_level = 1'b0; m_run = 0;
            m_glitch = 0; m_fp = 1'b0; m_rp = 1'b0;
        end else begin
            m_fp   = 1'b0;
            m_rp   = 1'b0;
            s2_now = m_p1;
            if (s2_now != m_level) begin
                m_run++;
                if (m_run == c_D + 1) begin
                    m_level = ~m_level;
                    m_fp    = m_level;
                    m_rp    = ~m_level;
                    m_run   = 0;
                end
            end else begin
                if (m_run > 0 && m_glitch < 255) m_glitch++;
                m_run = 0;
            end
            m_p1 = m_p0;
            m_p0 = pressed;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_raw = 1'b0; btn_raw_ah = 1'b0;
        tick(); tick();
        n_checks++;
        if ({flick, flick_pulse, release_pulse, glitch_cnt} !== 11'd0)
            $display("FAIL reset_outputs: got %h want 000", {flick, flick_pulse, release_pulse, glitch_cnt});
        else n_pass++;
        reset = 1'b0; btn_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({flick, flick_pulse, release_pulse, glitch_cnt} !== {m_level, m_fp, m_rp, 8'(m_glitch)})
                $display("FAIL reset_idle cyc %0d: got %h want %h", i, {flick, flick_pulse, release_pulse, glitch_cnt}, {m_level, m_fp, m_rp, 8'(m_glitch)});
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({flick, flick_pulse, release_pulse} !== {1'(i >= 6), 1'(i == 6), 1'b0})
                $display("FAIL clean_press edge k+%0d: got %b want %b", i, {flick, flick_pulse, release_pulse}, {1'(i >= 6), 1'(i == 6), 1'b0});
            else n_pass++;
        end
        n_checks++;
        if (glitch_cnt !== 8'd0) $display("FAIL clean_press_glitch: got %0d want 0", glitch_cnt);
        else n_pass++;
        btn_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({flick, flick_pulse, release_pulse} !== {1'(i < 6), 1'b0, 1'(i == 6)})
                $display("FAIL clean_release edge k+%0d: got %b want %b", i, {flick, flick_pulse, release_pulse}, {1'(i < 6), 1'b0, 1'(i == 6)});
            else n_pass++;
        end
    endtask

    task automatic test_bouncy_press();
        int g0;
        int npulse;
        g0 = m_glitch;
        npulse = 0;
        btn_raw = 1'b0; tick(); npulse += int'(flick_pulse); tick(); npulse += int'(flick_pulse);
        btn_raw = 1'b1; tick(); npulse += int'(flick_pulse);
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            npulse += int'(flick_pulse);
            n_checks++;
            if (flick_pulse !== 1'(i == 6))
                $display("FAIL bouncy_pulse edge k+%0d: got %b want %b", i, flick_pulse, 1'(i == 6));
            else n_pass++;
        end
        n_checks++;
        if (glitch_cnt !== 8'(g0 + 1)) $display("FAIL bouncy_glitch: got %0d want %0d", glitch_cnt, g0 + 1);
        else n_pass++;
        n_checks++;
        if (npulse != 1) $display("FAIL bouncy_pulse_count: got %0d want 1", npulse);
        else n_pass++;
    endtask

    task automatic test_release_bounce();
        int g0;
        int bad;
        g0 = m_glitch;
        bad = 0;
        btn_raw = 1'b1; tick(); tick();
        btn_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (flick !== 1'b1 || release_pulse !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL release_bounce_level: got %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (glitch_cnt !== 8'(g0 + 1)) $display("FAIL release_bounce_glitch: got %0d want %0d", glitch_cnt, g0 + 1);
        else n_pass++;
        btn_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({flick, release_pulse} !== {1'(i < 6), 1'(i == 6)})
                $display("FAIL release_after_bounce edge k+%0d: got %b want %b", i, {flick, release_pulse}, {1'(i < 6), 1'(i == 6)});
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int nflick;
        int npulse;
        nflick = 0; npulse = 0;
        for (int n = 0; n < 300; n++) begin
            btn_raw = 1'b0;
            repeat (2) begin tick(); nflick += int'(flick); npulse += int'(flick_pulse) + int'(release_pulse); end
            btn_raw = 1'b1;
            repeat (4) begin tick(); nflick += int'(flick); npulse += int'(flick_pulse) + int'(release_pulse); end
        end
        n_checks++;
        if (glitch_cnt !== 8'hFF) $display("FAIL sat_glitch: got %h want ff", glitch_cnt);
        else n_pass++;
        n_checks++;
        if (nflick != 0 || npulse != 0) $display("FAIL sat_quiet: got flick=%0d pulses=%0d want 0/0", nflick, npulse);
        else n_pass++;
        n_checks++;
        if ({flick, flick_pulse, release_pulse, glitch_cnt} !== {m_level, m_fp, m_rp, 8'(m_glitch)})
            $display("FAIL sat_model: got %h want %h", {flick, flick_pulse, release_pulse, glitch_cnt}, {m_level, m_fp, m_rp, 8'(m_glitch)});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        btn_raw = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({flick, flick_pulse, release_pulse, glitch_cnt} !== 11'd0)
            $display("FAIL reset_mid_outputs: got %h want 000", {flick, flick_pulse, release_pulse, glitch_cnt});
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({flick, flick_pulse} !== {1'(i >= 6), 1'(i == 6)})
                $display("FAIL reset_mid_press edge r+%0d: got %b want %b", i, {flick, flick_pulse}, {1'(i >= 6), 1'(i == 6)});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                btn_raw = 1'($urandom_range(0, 1));
                hold    = $urandom_range(1, 9);
            end
            reset = ($urandom_range(0, 149) == 0);
            tick();
            hold--;
            n_checks++;
            if ({flick, flick_pulse, release_pulse, glitch_cnt} !== {m_level, m_fp, m_rp, 8'(m_glitch)})
                $display("FAIL random cyc %0d: got %h want %h", i, {flick, flick_pulse, release_pulse, glitch_cnt}, {m_level, m_fp, m_rp, 8'(m_glitch)});
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    task automatic test_polarity();
        int bad;
        bad = 0;
        btn_raw = 1'b1; btn_raw_ah = 1'b0;
        repeat (20) begin tick(); if (flick_ah !== 1'b0 || flick_pulse_ah !== 1'b0) bad++; end
        n_checks++;
        if (bad != 0) $display("FAIL polarity_idle: got %0d bad cycles want 0", bad);
        else n_pass++;
        btn_raw_ah = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({flick_ah, flick_pulse_ah} !== {1'(i >= 6), 1'(i == 6)})
                $display("FAIL polarity_press edge k+%0d: got %b want %b", i, {flick_ah, flick_pulse_ah}, {1'(i >= 6), 1'(i == 6)});
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; btn_raw = 1'b1; btn_raw_ah = 1'b0;
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_release_bounce();
        test_saturation();
        test_reset_mid();
        test_random();
        test_polarity();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
